// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the syn_fifo_ext slice.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : values of the FWFT read-mode parameter
//   clog2()                        : constant log2, used to check ADDR_WIDTH
//   cnt_width()                    : width of pointers, counts and thresholds
package syn_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // One extra bit so that a count of exactly DEPTH is representable.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/syn_fifo_ext_if.sv
// Handshake / status bundle of syn_fifo_ext.
//   master : producer/consumer side (drives flush, din, wr_en, rd_en, thresholds)
//   slave  : the FIFO (drives dout, valid, flags, fifo_cnt, overflow, underflow)
// Optional macro SYN_FIFO_PEAK_EN adds peak_cnt (slave output).
interface syn_fifo_ext_if
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 9
);
    logic                               flush;
    logic [WIDTH-1:0]                   din;
    logic                               wr_en;
    logic                               rd_en;
    logic [cnt_width(ADDR_WIDTH)-1:0]   prog_full_thresh;
    logic [cnt_width(ADDR_WIDTH)-1:0]   prog_empty_thresh;
    logic [WIDTH-1:0]                   dout;
    logic                               valid;
    logic                               full;
    logic                               empty;
    logic                               prog_full;
    logic                               prog_empty;
    logic [cnt_width(ADDR_WIDTH)-1:0]   fifo_cnt;
    logic                               overflow;
    logic                               underflow;
`ifdef SYN_FIFO_PEAK_EN
    logic [cnt_width(ADDR_WIDTH)-1:0]   peak_cnt;
`endif

    modport master (
        output flush, din, wr_en, rd_en, prog_full_thresh, prog_empty_thresh,
        input  dout, valid, full, empty, prog_full, prog_empty, fifo_cnt,
               overflow, underflow
`ifdef SYN_FIFO_PEAK_EN
        , input peak_cnt
`endif
    );

    modport slave (
        input  flush, din, wr_en, rd_en, prog_full_thresh, prog_empty_thresh,
        output dout, valid, full, empty, prog_full, prog_empty, fifo_cnt,
               overflow, underflow
`ifdef SYN_FIFO_PEAK_EN
        , output peak_cnt
`endif
    );

endinterface

// File: rtl/syn_fifo_ram.sv
// Simple dual-port RAM, WIDTH x DEPTH: one write port, one registered read
// port with read enable (o_rdata holds between reads). No reset on the array
// or the read register so it maps onto block RAM.
//   i_clk                   : clock
//   i_we, i_waddr, i_wdata  : write port
//   i_re, i_raddr           : read request
//   o_rdata                 : read data, valid the cycle after i_re
module syn_fifo_ram #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/syn_fifo_ext.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// runtime prog_full/prog_empty thresholds, full-range occupancy count,
// overflow/underflow pulses and synchronous flush.
//   sys_clk   : clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : syn_fifo_ext_if.slave (data, requests, thresholds, flags)
// Optional macro SYN_FIFO_PEAK_EN adds bus.peak_cnt, a running maximum of
// fifo_cnt cleared by reset and flush.
module syn_fifo_ext
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    syn_fifo_ext_if.slave bus
);

    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    if ((ADDR_WIDTH != clog2(DEPTH)) || (DEPTH < 4) || ((1 << ADDR_WIDTH) != DEPTH)
        || ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT))) begin : g_bad_cfg
        $error("syn_fifo_ext: DEPTH must be a power of two >= 4 with ADDR_WIDTH = log2(DEPTH), FWFT 0 or 1");
    end

    logic [CW-1:0]    r_wr_ptr, r_rd_ptr, r_cnt, w_cnt_next;
    logic             r_full, r_empty, r_pfull, r_pempty, r_ovf, r_udf;
    logic             w_wr_acc, w_rd_acc, w_ram_re, w_empty_next;
    logic [WIDTH-1:0] w_ram_q;

    // Acceptance uses the registered flags from the start of the cycle, so a
    // write while full is refused even if a read frees a slot on the same edge.
    assign w_wr_acc = bus.wr_en && !r_full;
    assign w_rd_acc = bus.rd_en && !r_empty;

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_wr_acc && !w_rd_acc)      w_cnt_next = r_cnt + C_ONE;
        else if (!w_wr_acc && w_rd_acc) w_cnt_next = r_cnt - C_ONE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_pfull  <= 1'b0;
            r_pempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_pfull  <= 1'b0;
            r_pempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_ONE;
            if (w_ram_re) r_rd_ptr <= r_rd_ptr + C_ONE;
            r_cnt    <= w_cnt_next;
            r_full   <= (w_cnt_next == C_DEPTH);
            r_empty  <= w_empty_next;
            r_pfull  <= (w_cnt_next >= bus.prog_full_thresh);
            r_pempty <= (w_cnt_next <= bus.prog_empty_thresh);
            r_ovf    <= bus.wr_en && r_full;
            r_udf    <= bus.rd_en && r_empty;
        end
    end

    syn_fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (sys_clk),
        .i_we    (w_wr_acc && !bus.flush),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (bus.din),
        .i_re    (w_ram_re && !bus.flush),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_ram_q)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Two-stage prefetch: RAM read register (r_qv marks it holding an
        // unpresented word) then the output register. fifo_cnt counts words in
        // both stages, while the pointers only track words still in the RAM.
        logic             r_qv, r_valid;
        logic [WIDTH-1:0] r_dout;
        logic             w_load, w_fetch, w_valid_next;

        assign w_load       = r_qv && (!r_valid || w_rd_acc);
        assign w_fetch      = (r_wr_ptr != r_rd_ptr) && (!r_qv || w_load);
        assign w_valid_next = w_load || (r_valid && !w_rd_acc);
        assign w_ram_re     = w_fetch;
        assign w_empty_next = !w_valid_next;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_qv    <= 1'b0;
                r_valid <= 1'b0;
                r_dout  <= '0;
            end else if (bus.flush) begin
                r_qv    <= 1'b0;
                r_valid <= 1'b0;
                r_dout  <= '0;
            end else begin
                if (w_fetch)     r_qv <= 1'b1;
                else if (w_load) r_qv <= 1'b0;
                r_valid <= w_valid_next;
                if (w_load) r_dout <= w_ram_q;
            end
        end

        assign bus.dout  = r_dout;
        assign bus.valid = r_valid;
    end else begin : g_std
        // The RAM read register is the output; r_live masks it to zero until
        // the first read after reset/flush so no stale word is ever shown.
        logic r_valid, r_live;

        assign w_ram_re     = w_rd_acc;
        assign w_empty_next = (w_cnt_next == '0);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_valid <= 1'b0;
                r_live  <= 1'b0;
            end else if (bus.flush) begin
                r_valid <= 1'b0;
                r_live  <= 1'b0;
            end else begin
                r_valid <= w_rd_acc;
                if (w_rd_acc) r_live <= 1'b1;
            end
        end

        assign bus.dout  = r_live ? w_ram_q : '0;
        assign bus.valid = r_valid;
    end

`ifdef SYN_FIFO_PEAK_EN
    logic [CW-1:0] r_peak;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                r_peak <= '0;
        else if (bus.flush)            r_peak <= '0;
        else if (w_cnt_next > r_peak)  r_peak <= w_cnt_next;
    end

    assign bus.peak_cnt = r_peak;
`endif

    assign bus.full       = r_full;
    assign bus.empty      = r_empty;
    assign bus.prog_full  = r_pfull;
    assign bus.prog_empty = r_pempty;
    assign bus.fifo_cnt   = r_cnt;
    assign bus.overflow   = r_ovf;
    assign bus.underflow  = r_udf;

endmodule

// File: tb/tb_syn_fifo_ext.sv
module tb_syn_fifo_ext;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    syn_fifo_ext_if #(.WIDTH(16), .ADDR_WIDTH(4)) if_s ();
    syn_fifo_ext_if #(.WIDTH(16), .ADDR_WIDTH(4)) if_f ();

    syn_fifo_ext #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4), .FWFT(0)) u_std (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (if_s)
    );

    syn_fifo_ext #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (if_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        if_s.flush = 0; if_s.din = '0; if_s.wr_en = 0; if_s.rd_en = 0;
        if_s.prog_full_thresh = 5'd12; if_s.prog_empty_thresh = 5'd2;
        if_f.flush = 0; if_f.din = '0; if_f.wr_en = 0; if_f.rd_en = 0;
        if_f.prog_full_thresh = 5'd12; if_f.prog_empty_thresh = 5'd2;
        tick();
        tick();

        // reset state
        chk("rst_cnt",    if_s.fifo_cnt, 0);
        chk("rst_empty",  if_s.empty, 1);
        chk("rst_pempty", if_s.prog_empty, 1);
        chk("rst_full",   if_s.full, 0);
        chk("rst_pfull",  if_s.prog_full, 0);
        chk("rst_valid",  if_s.valid, 0);
        chk("rst_dout",   if_s.dout, 0);
        chk("rst_ovf",    if_s.overflow, 0);
        chk("rst_udf",    if_s.underflow, 0);
        chk("rst_f_empty", if_f.empty, 1);
        chk("rst_f_valid", if_f.valid, 0);
        chk("rst_f_dout",  if_f.dout, 0);
        rst_n = 1'b1;
        tick();

        // fill 1..16, standard mode
        for (int i = 1; i <= 16; i++) begin
            if_s.din = 16'(i); if_s.wr_en = 1;
            tick();
            chk("fill_cnt",    if_s.fifo_cnt, i);
            chk("fill_full",   if_s.full, (i == 16) ? 1 : 0);
            chk("fill_pfull",  if_s.prog_full, (i >= 12) ? 1 : 0);
            chk("fill_pempty", if_s.prog_empty, (i <= 2) ? 1 : 0);
            chk("fill_empty",  if_s.empty, 0);
        end
        if_s.din = 16'd17;
        tick();
        chk("ovf_pulse", if_s.overflow, 1);
        chk("ovf_cnt",   if_s.fifo_cnt, 16);
        if_s.wr_en = 0;
        tick();
        chk("ovf_clear", if_s.overflow, 0);
`ifdef SYN_FIFO_PEAK_EN
        chk("peak_fill", if_s.peak_cnt, 16);
`endif

        // drain, data in order one edge after rd_en
        for (int i = 1; i <= 16; i++) begin
            if_s.rd_en = 1;
            tick();
            chk("drain_dout",  if_s.dout, i);
            chk("drain_valid", if_s.valid, 1);
            chk("drain_cnt",   if_s.fifo_cnt, 16 - i);
        end
        if_s.rd_en = 0;
        tick();
        chk("drain_empty", if_s.empty, 1);
        chk("drain_vpulse", if_s.valid, 0);
        chk("drain_hold",  if_s.dout, 16);
`ifdef SYN_FIFO_PEAK_EN
        chk("peak_drain", if_s.peak_cnt, 16);
`endif

        // underflow
        if_s.rd_en = 1;
        tick();
        chk("udf_pulse", if_s.underflow, 1);
        chk("udf_dout",  if_s.dout, 16);
        chk("udf_cnt",   if_s.fifo_cnt, 0);
        if_s.rd_en = 0;
        tick();
        chk("udf_clear", if_s.underflow, 0);
        if_s.rd_en = 1; if_s.wr_en = 1; if_s.din = 16'h0055;
        tick();
        chk("udfw_cnt",   if_s.fifo_cnt, 1);
        chk("udfw_pulse", if_s.underflow, 1);
        chk("udfw_valid", if_s.valid, 0);
        if_s.wr_en = 0;
        tick();
        chk("udfw_dout", if_s.dout, 16'h0055);
        if_s.rd_en = 0;

        // count 8, then simultaneous wr+rd across pointer wrap
        for (int k = 0; k < 8; k++) begin
            if_s.din = 16'(16'h0100 + k); if_s.wr_en = 1;
            tick();
        end
        chk("sim_start_cnt", if_s.fifo_cnt, 8);
        for (int k = 0; k < 20; k++) begin
            if_s.din = 16'(16'h0108 + k); if_s.wr_en = 1; if_s.rd_en = 1;
            tick();
            chk("sim_dout", if_s.dout, 16'h0100 + k);
            chk("sim_cnt",  if_s.fifo_cnt, 8);
        end
        if_s.rd_en = 0;
        for (int k = 0; k < 8; k++) begin
            if_s.din = 16'(16'h011C + k); if_s.wr_en = 1;
            tick();
        end
        chk("sim_full", if_s.full, 1);
        if_s.din = 16'h0999; if_s.wr_en = 1; if_s.rd_en = 1;
        tick();
        chk("fullrw_cnt",  if_s.fifo_cnt, 15);
        chk("fullrw_ovf",  if_s.overflow, 1);
        chk("fullrw_dout", if_s.dout, 16'h0114);
        if_s.wr_en = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("pre_flush_dout", if_s.dout, 16'h0114 + k);
        end
        if_s.rd_en = 0;
        tick();
        chk("pre_flush_cnt", if_s.fifo_cnt, 10);

        // flush with wr and rd asserted
        if_s.flush = 1; if_s.wr_en = 1; if_s.rd_en = 1;
        tick();
        chk("flush_cnt",    if_s.fifo_cnt, 0);
        chk("flush_empty",  if_s.empty, 1);
        chk("flush_pempty", if_s.prog_empty, 1);
        chk("flush_ovf",    if_s.overflow, 0);
        chk("flush_udf",    if_s.underflow, 0);
        chk("flush_valid",  if_s.valid, 0);
        chk("flush_dout",   if_s.dout, 0);
`ifdef SYN_FIFO_PEAK_EN
        chk("peak_flush", if_s.peak_cnt, 0);
`endif
        if_s.flush = 0; if_s.wr_en = 0; if_s.rd_en = 0;

        // runtime prog_full threshold
        for (int k = 0; k < 5; k++) begin
            if_s.din = 16'(16'h0200 + k); if_s.wr_en = 1;
            tick();
        end
        if_s.wr_en = 0;
        chk("thr_cnt",    if_s.fifo_cnt, 5);
        chk("thr_pfull0", if_s.prog_full, 0);
        if_s.prog_full_thresh = 5'd5;
        tick();
        chk("thr_pfull1", if_s.prog_full, 1);
        if_s.prog_full_thresh = 5'd12;
        if_s.rd_en = 1;
        tick();
        chk("thr_pfull_back", if_s.prog_full, 0);
        chk("post_flush_data", if_s.dout, 16'h0200);
        if_s.rd_en = 0;

        // FWFT: latency and pop
        if_f.din = 16'hA5A5; if_f.wr_en = 1;
        tick();
        chk("fw_n_valid", if_f.valid, 0);
        chk("fw_n_empty", if_f.empty, 1);
        chk("fw_n_cnt",   if_f.fifo_cnt, 1);
        if_f.din = 16'h0002;
        tick();
        chk("fw_n1_valid", if_f.valid, 0);
        chk("fw_n1_cnt",   if_f.fifo_cnt, 2);
        if_f.wr_en = 0;
        tick();
        chk("fw_n2_valid", if_f.valid, 1);
        chk("fw_n2_dout",  if_f.dout, 16'hA5A5);
        chk("fw_n2_empty", if_f.empty, 0);
        chk("fw_n2_cnt",   if_f.fifo_cnt, 2);
        if_f.rd_en = 1;
        tick();
        chk("fw_pop1_valid", if_f.valid, 1);
        chk("fw_pop1_dout",  if_f.dout, 16'h0002);
        chk("fw_pop1_cnt",   if_f.fifo_cnt, 1);
        tick();
        chk("fw_pop2_valid", if_f.valid, 0);
        chk("fw_pop2_empty", if_f.empty, 1);
        chk("fw_pop2_cnt",   if_f.fifo_cnt, 0);
        tick();
        chk("fw_udf", if_f.underflow, 1);
        if_f.rd_en = 0;

        // FWFT capacity is exactly DEPTH, then streaming drain
        for (int k = 0; k < 16; k++) begin
            if_f.din = 16'(16'h0300 + k); if_f.wr_en = 1;
            tick();
            chk("fw_fill_cnt", if_f.fifo_cnt, k + 1);
        end
        chk("fw_full", if_f.full, 1);
        if_f.din = 16'h0BAD;
        tick();
        chk("fw_ovf",     if_f.overflow, 1);
        chk("fw_ovf_cnt", if_f.fifo_cnt, 16);
        if_f.wr_en = 0;
        tick();
        tick();
        for (int k = 0; k < 16; k++) begin
            chk("fw_drain_valid", if_f.valid, 1);
            chk("fw_drain_dout",  if_f.dout, 16'h0300 + k);
            if_f.rd_en = 1;
            tick();
        end
        if_f.rd_en = 0;
        chk("fw_drain_end_valid", if_f.valid, 0);
        chk("fw_drain_end_cnt",   if_f.fifo_cnt, 0);

        // asynchronous reset mid-cycle
        for (int k = 0; k < 3; k++) begin
            if_s.din = 16'(16'h0400 + k); if_s.wr_en = 1;
            if_f.din = 16'(16'h0500 + k); if_f.wr_en = 1;
            tick();
        end
        if_s.wr_en = 0; if_f.wr_en = 0;
        if_s.rd_en = 1;
        tick();
        if_s.rd_en = 0;
        tick();
        chk("pre_arst_f_valid", if_f.valid, 1);
        chk("pre_arst_s_dout",  if_s.dout, 16'h0201);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt",    if_s.fifo_cnt, 0);
        chk("arst_empty",  if_s.empty, 1);
        chk("arst_pempty", if_s.prog_empty, 1);
        chk("arst_dout",   if_s.dout, 0);
        chk("arst_f_valid", if_f.valid, 0);
        chk("arst_f_dout",  if_f.dout, 0);
        chk("arst_f_cnt",   if_f.fifo_cnt, 0);
        #2 rst_n = 1'b1;
        if_s.din = 16'h0777; if_s.wr_en = 1;
        if_f.din = 16'h0888; if_f.wr_en = 1;
        tick();
        if_s.wr_en = 0; if_f.wr_en = 0;
        if_s.rd_en = 1;
        tick();
        if_s.rd_en = 0;
        chk("post_arst_s_dout", if_s.dout, 16'h0777);
        tick();
        chk("post_arst_f_dout",  if_f.dout, 16'h0888);
        chk("post_arst_f_valid", if_f.valid, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
